// File: rtl/colour_input_conditioner_if.sv
// Button/press bus between the raw colour inputs and the WAIT stage.
// The master side drives the buttons and enable; the slave side (the
// conditioner) returns cleaned press events and debug state.
interface colour_input_conditioner_if;
  logic       en;
  logic [3:0] btn_in;
  logic       press_valid;
  logic [1:0] press_colour;
  logic       multi_press;
  logic [1:0] state_dbg;

  modport master (
    output en,
    output btn_in,
    input  press_valid,
    input  press_colour,
    input  multi_press,
    input  state_dbg
  );

  modport slave (
    input  en,
    input  btn_in,
    output press_valid,
    output press_colour,
    output multi_press,
    output state_dbg
  );
endinterface

// File: rtl/colour_input_conditioner.sv
// Colour button conditioner: two-flop synchroniser, debounce FSM and chord
// rejection. Emits one press_valid pulse per clean single-button press and a
// multi_press pulse whenever more than one button is seen at once.
module colour_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  colour_input_conditioner_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_PRESS_DB   = 2'b01;
  localparam logic [1:0] ST_RELEASE_DB = 2'b10;

  logic [3:0]       s1_p0;
  logic [3:0]       sync_p1;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       held_btn;
  logic [1:0]       colour_q;
  logic             press_valid_q;
  logic             multi_press_q;

  logic [1:0]       nxt_state;
  logic [CNT_W-1:0] nxt_cnt;
  logic [3:0]       nxt_held;
  logic [1:0]       nxt_colour;
  logic             nxt_press_valid;
  logic             nxt_multi_press;

  logic             is_zero;
  logic             is_onehot;
  logic             is_multi;

  function automatic logic [1:0] encode_onehot(input logic [3:0] b);
    logic [1:0] code;
    code = 2'b00;
    if (b[1]) code = 2'b01;
    if (b[2]) code = 2'b10;
    if (b[3]) code = 2'b11;
    return code;
  endfunction

  // Classify the synchronised sample: none, exactly one, or a chord.
  always_comb begin
    is_zero   = (sync_p1 == 4'b0000);
    is_onehot = !is_zero && ((sync_p1 & (sync_p1 - 4'd1)) == 4'b0000);
    is_multi  = !is_zero && !is_onehot;
  end

  // Debounce FSM next-state; a dropped enable overrides every transition.
  always_comb begin
    nxt_state       = state;
    nxt_cnt         = cnt;
    nxt_held        = held_btn;
    nxt_colour      = colour_q;
    nxt_press_valid = 1'b0;
    nxt_multi_press = 1'b0;
    if (!bus.en) begin
      nxt_state = ST_RELEASE_DB;
      nxt_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_onehot) begin
            nxt_held   = sync_p1;
            nxt_colour = encode_onehot(sync_p1);
            nxt_cnt    = CNT_ONE;
            nxt_state  = ST_PRESS_DB;
          end else if (is_multi) begin
            nxt_multi_press = 1'b1;
            nxt_cnt         = '0;
            nxt_state       = ST_RELEASE_DB;
          end
        end
        ST_PRESS_DB: begin
          if (sync_p1 == held_btn) begin
            if (cnt == CNT_LAST) begin
              nxt_press_valid = 1'b1;
              nxt_cnt         = '0;
              nxt_state       = ST_RELEASE_DB;
            end else begin
              nxt_cnt = cnt + CNT_ONE;
            end
          end else if (is_zero) begin
            // Bounce back to nothing pressed: restart from IDLE quietly.
            nxt_cnt   = '0;
            nxt_state = ST_IDLE;
          end else begin
            // Different button or a chord: wait for a full release.
            nxt_multi_press = is_multi;
            nxt_cnt         = '0;
            nxt_state       = ST_RELEASE_DB;
          end
        end
        default: begin
          if (is_zero) begin
            if (cnt == CNT_LAST) begin
              nxt_cnt   = '0;
              nxt_state = ST_IDLE;
            end else begin
              nxt_cnt = cnt + CNT_ONE;
            end
          end else begin
            nxt_cnt = '0;
          end
        end
      endcase
    end
  end

  // ---- stage p0/p1: two-flop synchroniser on the raw buttons ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0   <= 4'b0000;
      sync_p1 <= 4'b0000;
    end else begin
      s1_p0   <= bus.btn_in;
      sync_p1 <= s1_p0;
    end
  end

  // ---- stage p2: FSM state, counters and registered pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RELEASE_DB;
      cnt           <= '0;
      held_btn      <= 4'b0000;
      colour_q      <= 2'b00;
      press_valid_q <= 1'b0;
      multi_press_q <= 1'b0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      held_btn      <= nxt_held;
      colour_q      <= nxt_colour;
      press_valid_q <= nxt_press_valid;
      multi_press_q <= nxt_multi_press;
    end
  end

  assign bus.press_valid  = press_valid_q;
  assign bus.press_colour = colour_q;
  assign bus.multi_press  = multi_press_q;
  assign bus.state_dbg    = state;

endmodule

// File: doc/colour_input_conditioner.md
# colour_input_conditioner

Conditions the four raw colour buttons before they reach the WAIT stage. It synchronises the buttons, debounces them, and rejects chords (more than one button at once). Each clean single-button press produces exactly one `press_valid` pulse with the encoded colour. The block sits between `ui_in[3:0]` and the WAIT stage, replacing the raw OR-of-buttons strobe and the combinational colour decode.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: number of consecutive identical synchronised samples needed to accept a press or a release. Legal range is ≥2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  accept input. When low, the block drops any press in progress and no pulses are produced.
- `btn_in`  in  4  raw buttons, asynchronous, active-high; bit i is colour i.
- `press_valid`  out  1  registered one-cycle pulse: one accepted press.
- `press_colour`  out  2  encoded colour of the last press entering debounce. Encoding: `btn[0]`→00, `btn[1]`→01, `btn[2]`→10, `btn[3]`→11.
- `multi_press`  out  1  registered one-cycle pulse: a chord was detected.
- `state_dbg`  out  2  current state. IDLE=00, PRESS_DB=01, RELEASE_DB=10.

## Operation
- **Synchroniser.** Two flops per bit: `btn_in` → s1 → `sync[3:0]`. The FSM sees only `sync`.
- **Sample classes** (`sync` each edge):
  - ZERO: 0000.
  - ONEHOT: exactly one bit set.
  - MULTI: two or more bits set.
- **Count rule.** `cnt` counts consecutive qualifying samples. Reaching `DEBOUNCE_CYCLES` samples means the transition happens on the edge where `cnt==DEBOUNCE_CYCLES-1` and the sample still qualifies.
- **RELEASE_DB** (reset state, `cnt`=0):
  - ZERO: `cnt`++.
  - Any non-ZERO: `cnt`←0 and stay.
  - Nth consecutive ZERO: go to IDLE.
  - Buttons held through reset or enable are therefore never accepted.
- **IDLE:**
  - ZERO: stay.
  - ONEHOT: latch one-hot into `held_btn`, `press_colour`←encode, `cnt`←1, go to PRESS_DB.
  - MULTI: `multi_press`←1 for one cycle, `cnt`←0, go to RELEASE_DB.
- **PRESS_DB:**
  - `sync==held_btn`: `cnt`++.
  - Nth matching sample: `press_valid`←1 for one cycle, `cnt`←0, go to RELEASE_DB.
  - ZERO (bounce): `cnt`←0, go to IDLE, no pulse.
  - A different ONEHOT: go to RELEASE_DB, `cnt`←0, no pulse.
  - MULTI: `multi_press` pulse, go to RELEASE_DB, `cnt`←0.
- **`en` low.** Next edge goes to RELEASE_DB with `cnt`←0, overriding all of the above. `press_valid` and `multi_press` are forced 0 on that edge.
- **Colour hold.** `press_colour` holds between presses. It updates only on IDLE→PRESS_DB, so it is stable and correct while `press_valid` is high.
- **Pulse exclusivity.** `press_valid` and `multi_press` are never high in the same cycle. At most one `press_valid` per press-and-release of a button.

## Timing
- **Reset values:** `press_valid`=0, `multi_press`=0, `press_colour`=00, `state_dbg`=10, sync flops 0, `cnt`=0, `held_btn`=0000.
- **Reset deassertion.** Deassertion is synchronised by the top level. The block takes no action until the first edge after release.
- **Edge labels.** E0 is the edge where s1 first samples a new value. `sync` shows it after E1. The FSM first acts on it at E2.
- **Press latency.** For a stable ONEHOT from E0, IDLE→PRESS_DB at E2. `press_valid` is high for the single cycle after E(DEBOUNCE_CYCLES+1), and low after E(DEBOUNCE_CYCLES+2).
- **Release latency.** From the first ZERO sample in RELEASE_DB, IDLE is reached at the Nth consecutive ZERO edge. A new press can then enter PRESS_DB on the following edge.
- **Async reset mid-operation.** All outputs go to their reset values immediately (no clock needed), and any in-flight press is discarded.
- **Simultaneous events.** `en` low has priority over every FSM transition and pulse.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4.

1. **Reset, released buttons.** Reset with `btn_in`=0000, `en`=1 → outputs 0, `state_dbg`=10; `state_dbg`=00 after 4 edges; no pulses.
2. **Clean press.** From IDLE, `btn_in`=0100 held 20 cycles → `state_dbg`=01 after E2; one `press_valid` pulse in the cycle after E5 with `press_colour`=10; no further pulse until release and re-press.
3. **Bouncing press.** `btn_in` toggles 0001 (2 cycles) / 0000 (1 cycle) ×5, then 0000 → no `press_valid`; `state_dbg` ends 00.
4. **Chord.** `btn_in`=0011 held 10 cycles, then 0000 → one `multi_press` pulse, no `press_valid`; `state_dbg`=10 until 4 ZERO samples, then 00.
5. **Enable drop.** `btn_in`=1000 held, `en` dropped at the PRESS_DB edge with `cnt`=2 → no `press_valid`; `state_dbg`=10. With `en` restored and the button still held, no press until released ≥4 cycles and re-pressed; the re-press gives `press_colour`=11 and one pulse.
6. **Async reset mid-debounce.** `rst_n` pulsed low mid-PRESS_DB with `press_colour`=01 → outputs reset immediately without a clock edge; `press_colour`=00; a held button gives no `press_valid` until released.
